// File: rtl/alu_apb_bridge.sv
// alu_apb_bridge
//   APB3 slave front-end for the ALU. Holds the ALU operand and opcode
//   registers, launches an operation on every accepted OP write, then
//   captures the ALU result, status, error and op_rdy into read-only
//   registers. A sticky DONE flag marks completion.
//
// Register map (byte-wide, M = 8):
//   0 ARG_A  RW        1 ARG_B  RW        2 OP  RW [N-1:0]
//   3 RESULT RO        4 STATUS RO {DONE, BUSY, op_rdy, error, status[3:0]}
//   5 IRQ_EN RW bit 0 (ALU_BRIDGE_IRQ_EN builds only; otherwise unmapped)
//
// Ports:
//   i_clk, i_reset                  clock, synchronous active-low reset
//   i_psel/i_penable/i_pwrite       APB control
//   i_paddr, i_pwdata               APB address / write data
//   o_prdata, o_pready, o_pslverr   APB response (o_pready combinational)
//   o_alu_op, o_alu_arg_A/B         ALU operand/opcode drive
//   i_alu_result/status/op_rdy/error  registered ALU outputs
//   o_irq                           DONE & IRQ_EN[0], registered
//                                   (only with ALU_BRIDGE_IRQ_EN defined)
//
// Build option: define ALU_BRIDGE_IRQ_EN to add o_irq and register 5.

module alu_apb_bridge #(
    parameter int N       = 4,
    parameter int M       = 8,
    parameter int K       = 8,
    parameter int ALU_LAT = 1
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_psel,
    input  logic         i_penable,
    input  logic         i_pwrite,
    input  logic [2:0]   i_paddr,
    input  logic [M-1:0] i_pwdata,
    output logic [M-1:0] o_prdata,
    output logic         o_pready,
    output logic         o_pslverr,
    output logic [N-1:0] o_alu_op,
    output logic [M-1:0] o_alu_arg_A,
    output logic [M-1:0] o_alu_arg_B,
    input  logic [K-1:0] i_alu_result,
    input  logic [3:0]   i_alu_status,
    input  logic         i_alu_op_rdy,
    input  logic         i_alu_error
`ifdef ALU_BRIDGE_IRQ_EN
    ,
    output logic         o_irq
`endif
);

    localparam int CW = $clog2(ALU_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_CAPTURE
    } state_t;

    state_t         r_state;
    state_t         w_next_state;

    logic [M-1:0]   r_arg_a;
    logic [M-1:0]   r_arg_b;
    logic [N-1:0]   r_op;
    logic [K-1:0]   r_result;
    logic [5:0]     r_status;
    logic           r_done;
    logic [CW-1:0]  r_cnt;
`ifdef ALU_BRIDGE_IRQ_EN
    logic           r_irq_en;
    logic           r_irq;
`endif

    logic           w_busy;
    logic           w_capture;
    logic           w_access;
    logic           w_mapped;
    logic           w_err;
    logic           w_stall;
    logic           w_accept;
    logic           w_launch;
    logic [M-1:0]   w_rdata;

    assign o_alu_op    = r_op;
    assign o_alu_arg_A = r_arg_a;
    assign o_alu_arg_B = r_arg_b;
`ifdef ALU_BRIDGE_IRQ_EN
    assign o_irq       = r_irq;
`endif

    // APB decode and response
    always_comb begin
        w_busy    = (r_state != S_IDLE);
        w_capture = (r_state == S_CAPTURE);
        w_access  = i_reset && i_psel && i_penable;
`ifdef ALU_BRIDGE_IRQ_EN
        w_mapped  = (i_paddr <= 3'd5);
`else
        w_mapped  = (i_paddr <= 3'd4);
`endif
        w_err     = !w_mapped || (i_pwrite && (i_paddr == 3'd3 || i_paddr == 3'd4));
        // Operand/opcode writes must not disturb an operation in flight.
        w_stall   = i_pwrite && (i_paddr <= 3'd2) && w_busy;
        o_pready  = w_access && !w_stall;
        o_pslverr = o_pready && w_err;
        w_accept  = o_pready && !w_err;
        w_launch  = w_accept && i_pwrite && (i_paddr == 3'd2);

        w_rdata = '0;
        case (i_paddr)
            3'd0: w_rdata = r_arg_a;
            3'd1: w_rdata = r_arg_b;
            3'd2: w_rdata[N-1:0] = r_op;
            3'd3: w_rdata[K-1:0] = r_result;
            3'd4: w_rdata[7:0] = {r_done, w_busy, r_status};
`ifdef ALU_BRIDGE_IRQ_EN
            3'd5: w_rdata[0] = r_irq_en;
`endif
            default: w_rdata = '0;
        endcase
        o_prdata = (w_accept && !i_pwrite) ? w_rdata : '0;
    end

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next state: WAIT lasts ALU_LAT cycles, CAPTURE one cycle
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (w_launch) w_next_state = S_WAIT;
            S_WAIT:    if (r_cnt == CW'(1)) w_next_state = S_CAPTURE;
            S_CAPTURE: w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    // Registers, counter, capture and DONE
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_arg_a  <= '0;
            r_arg_b  <= '0;
            r_op     <= '0;
            r_result <= '0;
            r_status <= '0;
            r_done   <= 1'b0;
            r_cnt    <= '0;
`ifdef ALU_BRIDGE_IRQ_EN
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
`endif
        end else begin
            if (w_accept && i_pwrite) begin
                case (i_paddr)
                    3'd0: r_arg_a <= i_pwdata;
                    3'd1: r_arg_b <= i_pwdata;
                    3'd2: r_op    <= i_pwdata[N-1:0];
`ifdef ALU_BRIDGE_IRQ_EN
                    3'd5: r_irq_en <= i_pwdata[0];
`endif
                    default: ;
                endcase
            end

            if (w_launch) begin
                r_cnt <= CW'(ALU_LAT);
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - CW'(1);
            end

            if (w_capture) begin
                r_result <= i_alu_result;
                r_status <= {i_alu_op_rdy, i_alu_error, i_alu_status};
            end

            // A launch always clears DONE. A RESULT read that lands on the
            // capture edge returned the previous result, so the fresh
            // capture keeps DONE set.
            if (w_launch) begin
                r_done <= 1'b0;
            end else if (w_capture) begin
                r_done <= 1'b1;
            end else if (w_accept && !i_pwrite && i_paddr == 3'd3) begin
                r_done <= 1'b0;
            end

`ifdef ALU_BRIDGE_IRQ_EN
            r_irq <= r_done && r_irq_en;
`endif
        end
    end

endmodule
